// File: rtl/timer_pkg.sv
// timer_pkg
//   Shared definitions for programmable_timer and timer_capture:
//   default widths, the capture record layout and its width helper.
package timer_pkg;

   localparam int COUNTER_DEF  = 19;
   localparam int PERIOD_W_DEF = 48;
   localparam int N_CH_DEF     = 4;

   // Capture record at default widths; period sits above counter so the
   // packed value compares in time order.
   typedef struct packed {
      logic [PERIOD_W_DEF-1:0] period;
      logic [COUNTER_DEF-1:0]  count;
   } cap_rec_t;

   function automatic int cap_rec_w(input int period_w, input int counter_w);
      return period_w + counter_w;
   endfunction

endpackage

// File: rtl/timer_capture.sv
// timer_capture
//   One event-capture channel: latches a {period,counter} stamp on ev when
//   the holding register is free, presents it with a valid/ready handshake
//   and raises a sticky overflow flag when an event is dropped.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-low
//   ev         event strobe
//   cap_ready  consumer accepts the current record
//   stamp      {period,counter} visible this cycle
//   cap_valid  record held
//   cap_data   held record
//   cap_ovf    sticky: an event arrived while the record was blocked
module timer_capture
   import timer_pkg::*;
#(
   parameter int REC_W = cap_rec_w(PERIOD_W_DEF, COUNTER_DEF)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ev,
   input  logic             cap_ready,
   input  logic [REC_W-1:0] stamp,
   output logic             cap_valid,
   output logic [REC_W-1:0] cap_data,
   output logic             cap_ovf
);

   logic             valid_q, valid_d;
   logic [REC_W-1:0] data_q, data_d;
   logic             ovf_q, ovf_d;
   logic             take;

   // The register is free either when empty or when being drained this cycle.
   assign take = ev && (!valid_q || cap_ready);

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ovf_d   = ovf_q;
      if (valid_q && cap_ready) begin
         valid_d = 1'b0;
         ovf_d   = 1'b0;
      end
      if (take) begin
         valid_d = 1'b1;
         data_d  = stamp;
      end else if (ev && valid_q) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
      end
   end

   assign cap_valid = valid_q;
   assign cap_data  = data_q;
   assign cap_ovf   = ovf_q;

endmodule

// File: rtl/programmable_timer.sv
// programmable_timer
//   Free-running period timer with a programmable terminal count, external
//   resync and optional per-channel event timestamp capture.
//   Capture channels are built only when macro TIMER_CAPTURE_EN is defined;
//   otherwise the capture outputs are tied to 0 and ev/cap_ready are ignored.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active-low
//   tc           terminal count, staged on tc_load
//   tc_load      strobe: stage tc (applied at next wrap or sync)
//   sync         strobe: restart counter at 0, load period from sync_period
//   sync_period  period value loaded on sync
//   counter      current count, 0..tc_active
//   period       completed-period count, wraps silently
//   period_done  one-cycle pulse in the cycle counter returns to 0
//   ev           per-channel event strobes
//   cap_valid    per-channel record valid
//   cap_ready    per-channel record accept
//   cap_data     per-channel {period,counter}, channel 0 in the LSBs
//   cap_ovf      per-channel sticky overflow
module programmable_timer
   import timer_pkg::*;
#(
   parameter int COUNTER  = COUNTER_DEF,
   parameter int PERIOD_W = PERIOD_W_DEF,
   parameter int N_CH     = N_CH_DEF
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [COUNTER-1:0]               tc,
   input  logic                             tc_load,
   input  logic                             sync,
   input  logic [PERIOD_W-1:0]              sync_period,
   output logic [COUNTER-1:0]               counter,
   output logic [PERIOD_W-1:0]              period,
   output logic                             period_done,
   input  logic [N_CH-1:0]                  ev,
   output logic [N_CH-1:0]                  cap_valid,
   input  logic [N_CH-1:0]                  cap_ready,
   output logic [N_CH*(PERIOD_W+COUNTER)-1:0] cap_data,
   output logic [N_CH-1:0]                  cap_ovf
);

   localparam int REC_W = cap_rec_w(PERIOD_W, COUNTER);

   logic [COUNTER-1:0]  counter_q, counter_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                period_done_q, period_done_d;
   logic [COUNTER-1:0]  tc_active_q, tc_active_d;
   logic [COUNTER-1:0]  tc_staged_q, tc_staged_d;
   logic                wrap;

   assign wrap = (counter_q == tc_active_q);

   always_comb begin
      counter_d     = counter_q + COUNTER'(1);
      period_d      = period_q;
      period_done_d = 1'b0;
      tc_active_d   = tc_active_q;
      tc_staged_d   = tc_load ? tc : tc_staged_q;
      // Sync takes priority over a coincident wrap and swallows its pulse.
      if (sync) begin
         counter_d   = '0;
         period_d    = sync_period;
         tc_active_d = tc_staged_q;
      end else if (wrap) begin
         counter_d     = '0;
         period_d      = period_q + PERIOD_W'(1);
         period_done_d = 1'b1;
         tc_active_d   = tc_staged_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         counter_q     <= '0;
         period_q      <= '0;
         period_done_q <= 1'b0;
         tc_active_q   <= '1;
         tc_staged_q   <= '1;
      end else begin
         counter_q     <= counter_d;
         period_q      <= period_d;
         period_done_q <= period_done_d;
         tc_active_q   <= tc_active_d;
         tc_staged_q   <= tc_staged_d;
      end
   end

   assign counter     = counter_q;
   assign period      = period_q;
   assign period_done = period_done_q;

`ifdef TIMER_CAPTURE_EN
   logic [REC_W-1:0] stamp;

   // Stamps are the registered values, so a capture alongside sync sees
   // the pre-sync time.
   assign stamp = {period_q, counter_q};

   for (genvar i = 0; i < N_CH; i++) begin : g_cap
      timer_capture #(
         .REC_W(REC_W)
      ) u_cap (
         .clk       (clk),
         .rst       (rst),
         .ev        (ev[i]),
         .cap_ready (cap_ready[i]),
         .stamp     (stamp),
         .cap_valid (cap_valid[i]),
         .cap_data  (cap_data[i*REC_W +: REC_W]),
         .cap_ovf   (cap_ovf[i])
      );
   end
`else
   logic unused_cap_inputs;

   assign unused_cap_inputs = ^{ev, cap_ready};
   assign cap_valid = '0;
   assign cap_data  = '0;
   assign cap_ovf   = '0;
`endif

endmodule

// File: tb/tb_programmable_timer.sv
// tb_programmable_timer
//   Directed bench for programmable_timer built with narrow widths
//   (COUNTER=8, PERIOD_W=8, N_CH=4) so the reset-default period is 256 cycles
//   and period wrap is reachable. Capture checks follow TIMER_CAPTURE_EN.
module tb_programmable_timer;

   localparam int CW = 8;
   localparam int PW = 8;
   localparam int NC = 4;

   logic                    clk;
   logic                    rst;
   logic [CW-1:0]           tc;
   logic                    tc_load;
   logic                    sync;
   logic [PW-1:0]           sync_period;
   logic [CW-1:0]           counter;
   logic [PW-1:0]           period;
   logic                    period_done;
   logic [NC-1:0]           ev;
   logic [NC-1:0]           cap_valid;
   logic [NC-1:0]           cap_ready;
   logic [NC*(PW+CW)-1:0]   cap_data;
   logic [NC-1:0]           cap_ovf;

   int n_chk;
   int n_err;

   programmable_timer #(
      .COUNTER  (CW),
      .PERIOD_W (PW),
      .N_CH     (NC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tc          (tc),
      .tc_load     (tc_load),
      .sync        (sync),
      .sync_period (sync_period),
      .counter     (counter),
      .period      (period),
      .period_done (period_done),
      .ev          (ev),
      .cap_valid   (cap_valid),
      .cap_ready   (cap_ready),
      .cap_data    (cap_data),
      .cap_ovf     (cap_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step_chk(input string tag, input int c, input int p, input logic d);
      tick();
      chk({tag, ".counter"}, counter, c);
      chk({tag, ".period"}, period, p);
      chk({tag, ".done"}, period_done, d);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".counter"}, counter, 0);
      chk({tag, ".period"}, period, 0);
      chk({tag, ".done"}, period_done, 0);
      chk({tag, ".valid"}, cap_valid, 0);
      chk({tag, ".ovf"}, cap_ovf, 0);
      chk({tag, ".data"}, cap_data, 0);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst = 1'b0; tc = '0; tc_load = 1'b0; sync = 1'b0; sync_period = '0;
      ev = '0; cap_ready = '0;
      tick();
      tick();
      chk_reset_state("reset");

      // First period runs to the reset default 255, then tc=4 applies.
      rst = 1'b1; tc = 8'd4; tc_load = 1'b1;
      step_chk("load4", 1, 0, 0);
      tc_load = 1'b0;
      repeat (253) tick();
      step_chk("pre_wrap", 255, 0, 0);
      step_chk("wrap1", 0, 1, 1);
      for (int k = 1; k <= 15; k++) step_chk("tc4", k % 5, 1 + k / 5, (k % 5) == 0);

      // tc=9 staged, then tc=2 loaded mid-period at counter 3.
      tc = 8'd9; tc_load = 1'b1;
      step_chk("stage9", 1, 4, 0);
      tc_load = 1'b0;
      for (int k = 2; k <= 4; k++) step_chk("tc4_tail", k, 4, 0);
      step_chk("apply9", 0, 5, 1);
      for (int k = 1; k <= 3; k++) step_chk("tc9", k, 5, 0);
      tc = 8'd2; tc_load = 1'b1;
      step_chk("stage2", 4, 5, 0);
      tc_load = 1'b0;
      for (int k = 5; k <= 9; k++) step_chk("tc9_tail", k, 5, 0);
      step_chk("apply2", 0, 6, 1);
      step_chk("tc2_a", 1, 6, 0);
      step_chk("tc2_b", 2, 6, 0);
      step_chk("tc2_c", 0, 7, 1);

      // Sync coincident with a wrap: no pulse, no increment.
      step_chk("tc2_d", 1, 7, 0);
      step_chk("tc2_e", 2, 7, 0);
      sync = 1'b1; sync_period = 8'hA5;
      step_chk("sync_wrap", 0, 'hA5, 0);
      sync = 1'b0;
      step_chk("post_sync_a", 1, 'hA5, 0);
      step_chk("post_sync_b", 2, 'hA5, 0);
      step_chk("post_sync_c", 0, 'hA6, 1);

      // Mid-period sync applies the staged tc immediately.
      tc = 8'd6; tc_load = 1'b1;
      step_chk("stage6", 1, 'hA6, 0);
      tc_load = 1'b0;
      sync = 1'b1; sync_period = 8'h10;
      step_chk("sync_mid", 0, 'h10, 0);
      sync = 1'b0;
      for (int k = 1; k <= 6; k++) step_chk("tc6", k, 'h10, 0);
      step_chk("tc6_wrap", 0, 'h11, 1);

`ifdef TIMER_CAPTURE_EN
      tc = 8'd9; tc_load = 1'b1;
      step_chk("stage9b", 1, 'h11, 0);
      tc_load = 1'b0;
      sync = 1'b1; sync_period = 8'd2;
      step_chk("sync2", 0, 2, 0);
      sync = 1'b0;
      for (int k = 1; k <= 7; k++) step_chk("to7", k, 2, 0);

      ev = 4'b0010;
      tick();
      chk("cap1.valid", cap_valid, 4'b0010);
      chk("cap1.data", cap_data[31:16], 16'h0207);
      chk("cap1.ovf", cap_ovf, 4'b0000);
      tick();
      chk("ovf1.ovf", cap_ovf, 4'b0010);
      chk("ovf1.data", cap_data[31:16], 16'h0207);
      chk("ovf1.valid", cap_valid, 4'b0010);
      ev = '0; cap_ready = 4'b0010;
      tick();
      chk("hs1.valid", cap_valid, 4'b0000);
      chk("hs1.ovf", cap_ovf, 4'b0000);
      chk("hs1.counter", counter, 0);
      chk("hs1.period", period, 3);
      cap_ready = '0;

      // Event in the handshake cycle replaces the record.
      ev = 4'b0001;
      tick();
      chk("cap0.data", cap_data[15:0], 16'h0300);
      ev = 4'b0001; cap_ready = 4'b0001;
      tick();
      chk("cap0_hs.valid", cap_valid, 4'b0001);
      chk("cap0_hs.data", cap_data[15:0], 16'h0301);
      ev = '0;
      tick();
      chk("cap0_clr.valid", cap_valid, 4'b0000);
      cap_ready = '0;

      // Capture alongside sync records pre-sync time.
      ev = 4'b0100; sync = 1'b1; sync_period = 8'h40;
      tick();
      chk("cap2.data", cap_data[47:32], 16'h0303);
      chk("cap2.valid", cap_valid, 4'b0100);
      chk("cap2.counter", counter, 0);
      chk("cap2.period", period, 'h40);
      sync = 1'b0;
      ev = 4'b1000;
      tick();
      chk("cap3.valid", cap_valid, 4'b1100);
      ev = '0; rst = 1'b0;
      tick();
      chk_reset_state("reset_mid_cap");
      rst = 1'b1;
`else
      ev = '1; cap_ready = '0;
      for (int k = 1; k <= 6; k++) begin
         step_chk("nocap", k, 'h11, 0);
         chk("nocap.valid", cap_valid, 0);
         chk("nocap.data", cap_data, 0);
      end
      step_chk("nocap_wrap", 0, 'h12, 1);
      ev = '0; rst = 1'b0;
      tick();
      chk_reset_state("reset_nocap");
      rst = 1'b1;
`endif

      // tc=0: counter pinned at 0, pulse and increment every cycle, period wraps.
      tc = 8'd0; tc_load = 1'b1;
      step_chk("stage0", 1, 0, 0);
      tc_load = 1'b0;
      sync = 1'b1; sync_period = 8'hFD;
      step_chk("sync_fd", 0, 'hFD, 0);
      sync = 1'b0;
      step_chk("tc0_a", 0, 'hFE, 1);
      step_chk("tc0_b", 0, 'hFF, 1);
      step_chk("tc0_c", 0, 'h00, 1);
      step_chk("tc0_d", 0, 'h01, 1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
